// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle for sram_bus_arbiter: inst and data requester ports plus shared memory port.
// master = arbiter view; slave = pipeline/bridge environment view.
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr,
    input  data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr,
    output mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr,
    output data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr,
    input  mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Inst/data arbiter onto one SRAM-like port with an in-order response ID FIFO.
// Optional SRAM_ARB_RR_EN: round-robin selection instead of data-over-inst priority.
module sram_bus_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic clk,
  input  logic resetn,
  sram_bus_arbiter_if.master bus,
  output logic rsp_err
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ids [OUTSTANDING];
  logic          lock_vld;
  logic          lock_id;
  logic          sel_vld;
  logic          sel_id;
  logic          sel_req;
  logic          push;
  logic          pop;
  logic          head_id;
  logic          empty;
`ifdef SRAM_ARB_RR_EN
  logic          rr_ptr;
`endif

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 1'b0;
    priority case (1'b1)
      lock_vld: begin
        sel_vld = 1'b1;
        sel_id  = lock_id;
      end
      (bus.inst_req && bus.data_req): begin
        sel_vld = 1'b1;
`ifdef SRAM_ARB_RR_EN
        sel_id  = rr_ptr;
`else
        sel_id  = 1'b1;
`endif
      end
      bus.data_req: begin
        sel_vld = 1'b1;
        sel_id  = 1'b1;
      end
      bus.inst_req: begin
        sel_vld = 1'b1;
        sel_id  = 1'b0;
      end
      default: ;
    endcase
  end

  assign sel_req = sel_vld && (sel_id ? bus.data_req : bus.inst_req);
  // gate on registered count so a same-edge pop never frees a slot early
  assign bus.mem_req = resetn && sel_req && (count < CW'(OUTSTANDING));

  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_size  = 2'd0;
    bus.mem_addr  = 32'd0;
    bus.mem_wstrb = 4'd0;
    bus.mem_wdata = 32'd0;
    if (resetn && sel_vld) begin
      if (sel_id) begin
        bus.mem_wr    = bus.data_wr;
        bus.mem_size  = bus.data_size;
        bus.mem_addr  = bus.data_addr;
        bus.mem_wstrb = bus.data_wstrb;
        bus.mem_wdata = bus.data_wdata;
      end else begin
        bus.mem_size  = 2'd2;
        bus.mem_addr  = bus.inst_addr;
      end
    end
  end

  assign push = bus.mem_req && bus.mem_addr_ok;
  assign bus.inst_addr_ok = push && !sel_id;
  assign bus.data_addr_ok = push && sel_id;

  assign empty   = (count == '0);
  assign head_id = ids[rptr];
  assign pop     = resetn && bus.mem_data_ok && !empty;
  assign bus.inst_data_ok = pop && !head_id;
  assign bus.data_data_ok = pop && head_id;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (push) ids[wptr] <= sel_id;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push) begin
        lock_vld <= 1'b0;
      end else if (bus.mem_req) begin
        lock_vld <= 1'b1;
        lock_id  <= sel_id;
      end
      if (bus.mem_data_ok && empty) rsp_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_ptr <= 1'b0;
    else if (push) rr_ptr <= !sel_id;
  end
`endif
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with an in-order response scoreboard.
module tb_sram_bus_arbiter;
  typedef struct {
    logic        id;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic resetn;
  logic rsp_err;
  int   n_vec;
  int   n_err;
  exp_t sbq[$];
  logic first_id;

  sram_bus_arbiter_if bus ();

  sram_bus_arbiter #(.OUTSTANDING(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .rsp_err (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'd0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = 32'd0;
    bus.data_wstrb  = 4'd0;
    bus.data_wdata  = 32'd0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'd0;
  endtask

  task automatic idle();
    cyc();
    clr();
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [31:0] d);
    exp_t e;
    e.id    = id;
    e.rdata = d;
    sbq.push_back(e);
  endtask

  task automatic rsp();
    exp_t e;
    cyc();
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL rsp_queue observed=empty expected=entry");
    end else begin
      e = sbq.pop_front();
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = e.rdata;
      #1;
      chk("rsp_inst_data_ok", bus.inst_data_ok, {31'd0, !e.id});
      chk("rsp_data_data_ok", bus.data_data_ok, {31'd0, e.id});
      chk("rsp_rdata", e.id ? bus.data_rdata : bus.inst_rdata, e.rdata);
    end
  endtask

  task automatic drive_data(input logic wr, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d);
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = 2'd2;
    bus.data_addr  = a;
    bus.data_wstrb = s;
    bus.data_wdata = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_inst_addr_ok", bus.inst_addr_ok, 0);
    chk("rst_data_addr_ok", bus.data_addr_ok, 0);
    chk("rst_rsp_err", rsp_err, 0);
    cyc();
    cyc();
    resetn = 1'b1;

    // contention right after reset
`ifdef SRAM_ARB_RR_EN
    first_id = 1'b0;
`else
    first_id = 1'b1;
`endif
    cyc();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0100;
    drive_data(1'b1, 32'h8000_0040, 4'hF, 32'hDEAD_BEEF);
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("cont1_data_addr_ok", bus.data_addr_ok, {31'd0, first_id});
    chk("cont1_inst_addr_ok", bus.inst_addr_ok, {31'd0, !first_id});
    chk("cont1_mem_wr", bus.mem_wr, {31'd0, first_id});
    chk("cont1_mem_wstrb", bus.mem_wstrb, first_id ? 4'hF : 4'h0);
    push_exp(first_id, 32'hAAAA_0001);
    cyc();
    if (first_id) bus.data_req = 1'b0;
    else bus.inst_req = 1'b0;
    #1;
    chk("cont2_data_addr_ok", bus.data_addr_ok, {31'd0, !first_id});
    chk("cont2_inst_addr_ok", bus.inst_addr_ok, {31'd0, first_id});
    chk("cont2_mem_addr", bus.mem_addr,
        first_id ? 32'hBFC0_0100 : 32'h8000_0040);
    push_exp(!first_id, 32'hAAAA_0002);
    idle();
    rsp();
    rsp();
    idle();

    // inst only
    cyc();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0000;
    #1;
    chk("inst_mem_req", bus.mem_req, 1);
    chk("inst_mem_addr", bus.mem_addr, 32'hBFC0_0000);
    chk("inst_mem_size", bus.mem_size, 2);
    chk("inst_addr_ok_wait", bus.inst_addr_ok, 0);
    cyc();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("inst_addr_ok", bus.inst_addr_ok, 1);
    push_exp(1'b0, 32'h3C08_0001);
    idle();
    chk("inst_idle_req", bus.mem_req, 0);
    rsp();
    idle();

    // lock: inst stalled 3 cycles, data rises in cycle 2
    cyc();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0200;
    #1;
    chk("lock_c1_addr", bus.mem_addr, 32'hBFC0_0200);
    cyc();
    drive_data(1'b0, 32'h8000_0080, 4'h0, 32'd0);
    #1;
    chk("lock_c2_addr", bus.mem_addr, 32'hBFC0_0200);
    chk("lock_c2_data_ok", bus.data_addr_ok, 0);
    cyc();
    #1;
    chk("lock_c3_addr", bus.mem_addr, 32'hBFC0_0200);
    cyc();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("lock_c4_addr", bus.mem_addr, 32'hBFC0_0200);
    chk("lock_c4_inst_ok", bus.inst_addr_ok, 1);
    push_exp(1'b0, 32'h1234_5678);
    cyc();
    bus.inst_req = 1'b0;
    #1;
    chk("lock_c5_data_ok", bus.data_addr_ok, 1);
    chk("lock_c5_addr", bus.mem_addr, 32'h8000_0080);
    push_exp(1'b1, 32'h8765_4321);
    idle();
    rsp();
    rsp();
    idle();

    // full FIFO
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_data(1'b0, 32'h9000_0000 + 32'(i * 4), 4'h0, 32'd0);
      bus.mem_addr_ok = 1'b1;
      #1;
      chk($sformatf("full_acc%0d", i), bus.data_addr_ok, 1);
      push_exp(1'b1, 32'h5500_0000 + 32'(i));
    end
    cyc();
    #1;
    chk("full_no_req", bus.mem_req, 0);
    chk("full_no_ok", bus.data_addr_ok, 0);
    rsp();
    bus.data_req    = 1'b1;
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("full_pop_same_cycle", bus.mem_req, 0);
    cyc();
    bus.mem_data_ok = 1'b0;
    #1;
    chk("full_next_req", bus.mem_req, 1);
    chk("full_next_ok", bus.data_addr_ok, 1);
    push_exp(1'b1, 32'h5500_0004);
    idle();
    for (int i = 0; i < 4; i++) rsp();
    idle();

    // ordering D,I,D
    cyc();
    drive_data(1'b0, 32'h8000_0100, 4'h0, 32'd0);
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("ord_d1", bus.data_addr_ok, 1);
    push_exp(1'b1, 32'h0000_0011);
    cyc();
    bus.data_req  = 1'b0;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0300;
    #1;
    chk("ord_i", bus.inst_addr_ok, 1);
    push_exp(1'b0, 32'h0000_0022);
    cyc();
    bus.inst_req = 1'b0;
    drive_data(1'b1, 32'h8000_0104, 4'h3, 32'h0000_BEEF);
    #1;
    chk("ord_d2", bus.data_addr_ok, 1);
    push_exp(1'b1, 32'h0000_0033);
    idle();
    rsp();
    rsp();
    rsp();
    idle();

    // response with empty FIFO
    chk("err_pre", rsp_err, 0);
    cyc();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hFFFF_FFFF;
    #1;
    chk("err_inst_ok", bus.inst_data_ok, 0);
    chk("err_data_ok", bus.data_data_ok, 0);
    idle();
    chk("err_set", rsp_err, 1);
    idle();
    chk("err_held", rsp_err, 1);

    // reset mid-burst
    cyc();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0400;
    bus.mem_addr_ok = 1'b1;
    cyc();
    cyc();
    resetn = 1'b0;
    #1;
    chk("rst_mid_mem_req", bus.mem_req, 0);
    chk("rst_mid_mem_addr", bus.mem_addr, 0);
    chk("rst_mid_inst_ok", bus.inst_addr_ok, 0);
    chk("rst_mid_rsp_err", rsp_err, 0);
    sbq.delete();
    cyc();
    clr();
    resetn = 1'b1;
    cyc();
    bus.mem_data_ok = 1'b1;
    #1;
    chk("rst_cnt_inst_ok", bus.inst_data_ok, 0);
    chk("rst_cnt_data_ok", bus.data_data_ok, 0);
    idle();
    chk("rst_cnt_err", rsp_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-requester arbiter that shares the single SRAM-like memory port between the fetch stage (inst side) and the EXE/MEM data path (data side). Tracks accepted-but-unanswered requests in an in-order ID FIFO so each `mem_data_ok` / `mem_rdata` beat returns to the requester that issued it. Sits between the pipeline stages and the AXI bridge at the CPU top.

## Interface
- `OUTSTANDING`, 4: maximum accepted requests awaiting `data_ok` (power of two, 2..8)
- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `inst_req`  in  1  fetch request valid
- `inst_addr`  in  32  fetch address (always word read, size 2)
- `inst_addr_ok`  out  1  fetch request accepted this cycle
- `inst_data_ok`  out  1  fetch read data valid this cycle
- `inst_rdata`  out  32  fetch read data
- `data_req`  in  1  load/store request valid
- `data_wr`  in  1  1 = store
- `data_size`  in  2  0 byte, 1 half, 2 word
- `data_addr`  in  32  load/store address
- `data_wstrb`  in  4  store byte enables
- `data_wdata`  in  32  store data
- `data_addr_ok`  out  1  data request accepted this cycle
- `data_data_ok`  out  1  load data / store ack valid this cycle
- `data_rdata`  out  32  load data, raw word (extension/LWL/LWR merge is done downstream)
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_addr[31:0]`, `mem_wstrb[3:0]`, `mem_wdata[31:0]`  out  shared port request
- `mem_addr_ok`  in  1  port accepted request
- `mem_data_ok`  in  1  port response valid
- `mem_rdata`  in  32  port response data
- `rsp_err`  out  1  sticky: `mem_data_ok` arrived with FIFO empty

## Operation
- Handshake: request transfers when `mem_req && mem_addr_ok`; grant ID (0 inst, 1 data) pushed into ID FIFO the same edge.
- `mem_req` = (selected requester's req) && (count < OUTSTANDING). FIFO full -> no request driven, both `*_addr_ok` = 0.
- Selection (default): data has fixed priority over inst.
- Lock: once `mem_req` is driven without `mem_addr_ok`, register `lock_vld`/`lock_id`; while locked the locked requester stays selected regardless of the other's req. Lock clears on the accepting edge. Requesters must hold req and payload stable until `addr_ok` (upstream contract).
- Mux: `mem_*` payload from selected requester; inst side drives `mem_wr`=0, `mem_size`=2, `mem_wstrb`=0, `mem_wdata`=0. With no selection, payload is 0.
- `inst_addr_ok` = `mem_addr_ok && mem_req && sel==0`; `data_addr_ok` likewise for sel==1.
- Response: `mem_data_ok` with FIFO non-empty routes to head ID (`inst_data_ok` or `data_data_ok`), pops head. `inst_rdata` and `data_rdata` both carry `mem_rdata` unconditionally.
- `mem_data_ok` with FIFO empty: no `*_data_ok`, no pop, `rsp_err` set until reset.
- Count arithmetic: width clog2(OUTSTANDING)+1; push only, +1; pop only, -1; push and pop same edge, unchanged. Pointers wrap modulo OUTSTANDING.

## Timing
- Reset (async assert, sync release via flops): count, pointers, `lock_vld`, `rsp_err` = 0, round-robin pointer = inst; all outputs 0.
- Request path combinational: req -> `mem_req` zero-cycle; `mem_addr_ok` -> `*_addr_ok` same cycle.
- Response path combinational: `mem_data_ok` -> `*_data_ok` same cycle; earliest response is the cycle after acceptance (same-cycle accept+response is a port protocol violation).
- Full with same-cycle pop: `mem_req` stays 0 that cycle (gate uses registered count); request issued next cycle.
- Reset mid-transaction: outstanding IDs dropped; the memory side is reset by the same `resetn`.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin selection; 1-bit pointer toggles to the other requester after each accepted request; when both request, pointer side wins. Lock rule unchanged.
- Undefined: fixed data-over-inst priority, no pointer flop.

## Test plan
- Inst only: `inst_req`=1, addr 0xBFC00000, `mem_addr_ok` 1 cycle later, `mem_data_ok` with 0x3C080001 two cycles later -> `inst_addr_ok` pulse, `inst_data_ok`=1 with `inst_rdata`=0x3C080001, `data_data_ok`=0.
- Contention: both req same cycle, `mem_addr_ok`=1 -> data accepted first (`mem_wr`/`mem_wstrb` from data), inst next cycle; with `SRAM_ARB_RR_EN`, inst accepted first after reset.
- Lock: inst req stalled by `mem_addr_ok`=0 for 3 cycles, data_req rises in cycle 2 -> `mem_addr`=inst address held all 4 cycles; data served after.
- Full: OUTSTANDING=4, accept 4 requests with no response -> `mem_req`=0 on 5th; one `mem_data_ok` -> 5th request driven next cycle.
- Ordering: accept D,I,D, return 0x11,0x22,0x33 -> `data_data_ok`/0x11, `inst_data_ok`/0x22, `data_data_ok`/0x33.
- Error/reset: `mem_data_ok` with empty FIFO -> `rsp_err`=1 held; assert `resetn`=0 mid-burst -> all outputs 0 immediately, count 0.
